booth_mult_arbiter: RTL and testbench
=====================================

// Module: booth_mult_arbiter
// PURPOSE
//  Shares one Boost_multiplier (sequential Booth, START/Done handshake) between NUM_REQ requesters.
//  Round-robin arbitration; issues one operation at a time, waits for Done, returns RESULT to the
//  winning requester. Sits between client blocks and the multiplier instance; passes operands/result bits unchanged.
// PARAMETERS
//  DATAWIDTH   8    operand width; result is 2*DATAWIDTH
//  NUM_REQ     4    number of requesters (2..8)
//  TIMEOUT_CYC 64   max WAIT cycles before abort (used only with MULT_TIMEOUT_EN)
// PORTS
//  CLK         in   1                  single clock, all logic on rising edge
//  RST         in   1                  reset, synchronous, active-high
//  REQ         in   NUM_REQ            per-requester request level
//  REQ_A       in   NUM_REQ*DATAWIDTH  operand A, requester i at [i*DATAWIDTH +: DATAWIDTH]
//  REQ_B       in   NUM_REQ*DATAWIDTH  operand B, same packing
//  GNT         out  NUM_REQ            one-hot 1-cycle accept pulse
//  RSP_VALID   out  NUM_REQ            one-hot 1-cycle result pulse to owner
//  RSP_RESULT  out  2*DATAWIDTH        result, held until next response
//  RSP_ERR     out  1                  qualifies RSP_VALID: 1 = aborted (timeout only)
//  BUSY        out  1                  high in any state except IDLE
//  M_RSTn      out  1                  multiplier reset, active-low
//  M_START     out  1                  multiplier start pulse
//  M_A, M_B    out  DATAWIDTH          multiplier operands, registered
//  M_RESULT    in   2*DATAWIDTH        multiplier result
//  M_DONE      in   1                  multiplier done
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state IDLE, rr pointer 0, GNT/RSP_VALID/M_START/RSP_ERR 0, RSP_RESULT/M_A/M_B 0, M_RSTn 0
//   while RST high, M_RSTn 1 from first cycle after RST low. Reset mid-op aborts silently: no RSP_VALID.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : if |REQ, winner w = first set bit searching from rr pointer upward (wrap at NUM_REQ-1);
//          register M_A/M_B from w's operands; next ISSUE. No REQ -> stay.
//   ISSUE: exactly 1 cycle; GNT[w]=1, M_START=1; rr pointer <= w+1 (mod NUM_REQ); next WAIT.
//   WAIT : M_START=0; M_DONE ignored on first WAIT cycle (stale-level guard); from 2nd cycle
//          M_DONE=1 -> capture M_RESULT into RSP_RESULT, next RESP.
//   RESP : RSP_VALID[w]=1 for 1 cycle, RSP_ERR=0; next IDLE.
//  Requester holds REQ and operands stable until it samples GNT; must drop REQ the cycle after GNT
//   unless it wants another op. REQ held continuously = new op after RESP, still round-robin.
//  Latency: REQ seen in IDLE at t -> GNT/M_START at t+1 -> RSP_VALID one cycle after Done capture.
//  Min gap: >=1 IDLE cycle between operations; at most one outstanding op.
//  REQ deasserted before GNT: the op completes anyway; its response is still issued.
//  Simultaneous REQ on all lines: served in strict rotation, no requester waits more than NUM_REQ ops.
//  M_A/M_B stay stable from ISSUE through RESP.
// CONFIGURATION
//  MULT_TIMEOUT_EN defined: WAIT counter counts from 0; if TIMEOUT_CYC cycles elapse without M_DONE,
//   M_RSTn=0 for 1 cycle, state RESP with RSP_ERR=1, RSP_RESULT=0; multiplier re-armed next cycle.
//  Not defined: no counter, WAIT is unbounded, RSP_ERR tied 0, M_RSTn = ~RST registered only.
// TESTING
//  1 Single: REQ[0]=1, A=3, B=5 -> GNT[0] 1 cycle after REQ, M_START 1 pulse, RSP_VALID[0], RESULT=15.
//  2 Contention: REQ=4'b0111 held, A/B = (2,4),(10,19),(32,45) -> grant order 0,1,2,0,...; results 8,190,1440.
//  3 Fairness: rr pointer at 2, REQ=4'b1001 -> grant 3 then 0; no double grant within one op.
//  4 Signed: A=8'hFD (-3), B=5 -> RSP_RESULT=16'hFFF1.
//  5 Reset mid-op: RST high during WAIT -> no RSP_VALID, BUSY=0, M_RSTn=0; next REQ[1] A=23,B=45 -> 1035.
//  6 Timeout (MULT_TIMEOUT_EN, TIMEOUT_CYC=16): hold M_DONE=0 -> after 16 WAIT cycles M_RSTn low 1 cycle,
//    RSP_VALID[w]=1, RSP_ERR=1, RSP_RESULT=0; following request completes normally.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter that shares one sequential Booth multiplier among NUM_REQ clients
// Defining MULT_TIMEOUT_EN adds an abort path for a multiplier that never raises M_DONE.
module booth_mult_arbiter #(
   parameter int DATAWIDTH   = 8,
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_REQ-1:0]           REQ,
   input  logic [NUM_REQ*DATAWIDTH-1:0] REQ_A,
   input  logic [NUM_REQ*DATAWIDTH-1:0] REQ_B,
   output logic [NUM_REQ-1:0]           GNT,
   output logic [NUM_REQ-1:0]           RSP_VALID,
   output logic [2*DATAWIDTH-1:0]       RSP_RESULT,
   output logic                         RSP_ERR,
   output logic                         BUSY,
   output logic                         M_RSTn,
   output logic                         M_START,
   output logic [DATAWIDTH-1:0]         M_A,
   output logic [DATAWIDTH-1:0]         M_B,
   input  logic [2*DATAWIDTH-1:0]       M_RESULT,
   input  logic                         M_DONE
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]         state;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      pick;
   logic               pick_ok;
   logic               wait_first;
   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] pick_oh;

`ifdef MULT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wait_cnt;
   logic          err_q;
   assign RSP_ERR = err_q;
`else
   assign RSP_ERR = 1'b0;
`endif

   // Scan downward so the last hit written is the first set bit at or above rr_ptr.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         logic [IW:0] idx;
         idx = {1'b0, rr_ptr} + (IW+1)'(i);
         if (idx >= (IW+1)'(NUM_REQ))
            idx = idx - (IW+1)'(NUM_REQ);
         if (REQ[idx[IW-1:0]]) begin
            pick    = idx[IW-1:0];
            pick_ok = 1'b1;
         end
      end
   end

   assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
   assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
   assign BUSY     = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         wait_first <= 1'b0;
         GNT        <= '0;
         RSP_VALID  <= '0;
         RSP_RESULT <= '0;
         M_START    <= 1'b0;
         M_RSTn     <= 1'b0;
         M_A        <= '0;
         M_B        <= '0;
`ifdef MULT_TIMEOUT_EN
         wait_cnt   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         GNT       <= '0;
         RSP_VALID <= '0;
         M_START   <= 1'b0;
         M_RSTn    <= 1'b1;
         case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  owner   <= pick;
                  M_A     <= REQ_A[pick*DATAWIDTH +: DATAWIDTH];
                  M_B     <= REQ_B[pick*DATAWIDTH +: DATAWIDTH];
                  GNT     <= pick_oh;
                  M_START <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rr_ptr     <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
               wait_first <= 1'b1;
`ifdef MULT_TIMEOUT_EN
               wait_cnt   <= '0;
`endif
               state      <= S_WAIT;
            end
            S_WAIT: begin
               // M_DONE may still be high from the previous op during the first WAIT cycle.
               wait_first <= 1'b0;
               if (!wait_first && M_DONE) begin
                  RSP_RESULT <= M_RESULT;
                  RSP_VALID  <= owner_oh;
`ifdef MULT_TIMEOUT_EN
                  err_q      <= 1'b0;
`endif
                  state      <= S_RESP;
               end
`ifdef MULT_TIMEOUT_EN
               else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  M_RSTn     <= 1'b0;
                  RSP_RESULT <= '0;
                  RSP_VALID  <= owner_oh;
                  err_q      <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  wait_cnt   <= wait_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
`ifdef MULT_TIMEOUT_EN
               err_q <= 1'b0;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - directed bench for booth_mult_arbiter with a behavioural multiplier stand-in
module tb_booth_mult_arbiter;
   localparam int DW   = 8;
   localparam int NR   = 4;
   localparam int TO   = 16;
   localparam int MLAT = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic [NR-1:0]    gnt;
   logic [NR-1:0]    rsp_valid;
   logic [2*DW-1:0]  rsp_result;
   logic             rsp_err;
   logic             busy;
   logic             m_rstn;
   logic             m_start;
   logic [DW-1:0]    m_a;
   logic [DW-1:0]    m_b;
   logic [2*DW-1:0]  m_result = '0;
   logic             m_done = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic start_d = 1'b0;
   int   mcnt = 0;
   logic m_hang = 1'b0;

   always #5 clk = ~clk;

   booth_mult_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
      .CLK(clk), .RST(rst), .REQ(req), .REQ_A(req_a), .REQ_B(req_b),
      .GNT(gnt), .RSP_VALID(rsp_valid), .RSP_RESULT(rsp_result), .RSP_ERR(rsp_err),
      .BUSY(busy), .M_RSTn(m_rstn), .M_START(m_start), .M_A(m_a), .M_B(m_b),
      .M_RESULT(m_result), .M_DONE(m_done)
   );

   // Multiplier stand-in: Done stays high until one cycle after the next start, so it looks stale.
   always @(posedge clk) begin
      if (!m_rstn) begin
         m_done  <= 1'b0;
         mcnt    <= 0;
         start_d <= 1'b0;
      end else begin
         start_d <= m_start;
         if (start_d) begin
            m_done <= 1'b0;
            mcnt   <= MLAT;
         end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
         end else if (mcnt == 1 && !m_hang) begin
            m_done   <= 1'b1;
            m_result <= 16'($signed(m_a) * $signed(m_b));
            mcnt     <= 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      req[i] = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_gnt(output logic [NR-1:0] g);
      int cyc;
      cyc = 0;
      g = gnt;
      while (g == '0 && cyc < 100) begin
         tick();
         cyc++;
         g = gnt;
      end
   endtask

   task automatic wait_rsp(output logic [NR-1:0] v, output logic [2*DW-1:0] r, output logic e,
                           output int cyc, output int starts);
      cyc = 0;
      starts = 0;
      v = '0;
      while (rsp_valid == '0 && cyc < 200) begin
         tick();
         cyc++;
         if (m_start) starts++;
      end
      v = rsp_valid;
      r = rsp_result;
      e = rsp_err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
      n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); end
      n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL rst_m_start: got %b expected 0", m_start); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_vec++; if (m_rstn !== 1'b0) begin n_err++; $display("FAIL rst_m_rstn: got %b expected 0", m_rstn); end
      n_vec++; if (rsp_result !== 16'h0) begin n_err++; $display("FAIL rst_result: got %h expected 0000", rsp_result); end
      n_vec++; if ({m_a, m_b} !== 16'h0) begin n_err++; $display("FAIL rst_operands: got %h expected 0000", {m_a, m_b}); end
      n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", rsp_err); end
      rst = 1'b0;
      tick();
      n_vec++; if (m_rstn !== 1'b1) begin n_err++; $display("FAIL rst_release_m_rstn: got %b expected 1", m_rstn); end
   endtask

   task automatic test_single();
      logic [NR-1:0]   v;
      logic [2*DW-1:0] r;
      logic            e;
      int              cyc, starts;
      set_op(0, 8'd3, 8'd5);
      tick();
      n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
      n_vec++; if (m_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b expected 1", m_start); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
      n_vec++; if ({m_a, m_b} !== 16'h0305) begin n_err++; $display("FAIL single_operands: got %h expected 0305", {m_a, m_b}); end
      req = '0;
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if (v !== 4'b0001) begin n_err++; $display("FAIL single_valid: got %b expected 0001", v); end
      n_vec++; if (r !== 16'd15) begin n_err++; $display("FAIL single_result: got %0d expected 15", r); end
      n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL single_err: got %b expected 0", e); end
      n_vec++; if (starts !== 0) begin n_err++; $display("FAIL single_extra_start: got %0d expected 0", starts); end
      tick();
      n_vec++; if ({busy, rsp_valid} !== 5'b0) begin n_err++; $display("FAIL single_pulse_end: got %b expected 00000", {busy, rsp_valid}); end
      n_vec++; if (rsp_result !== 16'd15) begin n_err++; $display("FAIL single_result_held: got %0d expected 15", rsp_result); end
   endtask

   task automatic test_contention();
      logic [NR-1:0]   exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
      logic [2*DW-1:0] exp_r [4] = '{16'd8, 16'd190, 16'd1440, 16'd8};
      logic [NR-1:0]   g, v;
      logic [2*DW-1:0] r;
      logic            e;
      int              cyc, starts;
      do_reset();
      set_op(0, 8'd2, 8'd4);
      set_op(1, 8'd10, 8'd19);
      set_op(2, 8'd32, 8'd45);
      for (int k = 0; k < 4; k++) begin
         wait_gnt(g);
         if (k == 3) req = '0;
         n_vec++; if (g !== exp_g[k]) begin n_err++; $display("FAIL contention_gnt%0d: got %b expected %b", k, g, exp_g[k]); end
         wait_rsp(v, r, e, cyc, starts);
         n_vec++; if (v !== exp_g[k]) begin n_err++; $display("FAIL contention_valid%0d: got %b expected %b", k, v, exp_g[k]); end
         n_vec++; if (r !== exp_r[k]) begin n_err++; $display("FAIL contention_result%0d: got %0d expected %0d", k, r, exp_r[k]); end
         n_vec++; if (starts !== 0) begin n_err++; $display("FAIL contention_double%0d: got %0d expected 0", k, starts); end
      end
   endtask

   task automatic test_fairness();
      logic [NR-1:0]   g, v;
      logic [2*DW-1:0] r;
      logic            e;
      int              cyc, starts;
      tick();
      set_op(1, 8'd1, 8'd1);
      wait_gnt(g);
      req = '0;
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if (r !== 16'd1) begin n_err++; $display("FAIL fair_setup_result: got %0d expected 1", r); end
      tick();
      set_op(3, 8'd6, 8'd7);
      set_op(0, 8'd2, 8'd4);
      wait_gnt(g);
      n_vec++; if (g !== 4'b1000) begin n_err++; $display("FAIL fair_gnt_first: got %b expected 1000", g); end
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if ({v, r} !== {4'b1000, 16'd42}) begin n_err++; $display("FAIL fair_rsp_first: got %b/%0d expected 1000/42", v, r); end
      n_vec++; if (starts !== 0) begin n_err++; $display("FAIL fair_double_first: got %0d expected 0", starts); end
      wait_gnt(g);
      req = '0;
      n_vec++; if (g !== 4'b0001) begin n_err++; $display("FAIL fair_gnt_second: got %b expected 0001", g); end
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if ({v, r} !== {4'b0001, 16'd8}) begin n_err++; $display("FAIL fair_rsp_second: got %b/%0d expected 0001/8", v, r); end
   endtask

   task automatic test_signed();
      logic [NR-1:0]   g, v;
      logic [2*DW-1:0] r;
      logic            e;
      int              cyc, starts;
      tick();
      set_op(2, 8'hFD, 8'h05);
      wait_gnt(g);
      req = '0;
      n_vec++; if (g !== 4'b0100) begin n_err++; $display("FAIL signed_gnt: got %b expected 0100", g); end
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if (r !== 16'hFFF1) begin n_err++; $display("FAIL signed_result: got %h expected fff1", r); end
   endtask

   task automatic test_reset_midop();
      logic [NR-1:0]   g, v;
      logic [2*DW-1:0] r;
      logic            e;
      int              cyc, starts, stray;
      tick();
      set_op(0, 8'd7, 8'd9);
      wait_gnt(g);
      req = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_vec++; if (m_rstn !== 1'b0) begin n_err++; $display("FAIL midrst_m_rstn: got %b expected 0", m_rstn); end
      tick();
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rsp_valid != '0) stray++;
      end
      n_vec++; if (stray !== 0) begin n_err++; $display("FAIL midrst_no_rsp: got %0d pulses expected 0", stray); end
      set_op(1, 8'd23, 8'd45);
      wait_gnt(g);
      req = '0;
      n_vec++; if (g !== 4'b0010) begin n_err++; $display("FAIL midrst_next_gnt: got %b expected 0010", g); end
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if ({v, r} !== {4'b0010, 16'd1035}) begin n_err++; $display("FAIL midrst_next_rsp: got %b/%0d expected 0010/1035", v, r); end
   endtask

`ifdef MULT_TIMEOUT_EN
   task automatic test_timeout();
      logic [NR-1:0]   g, v;
      logic [2*DW-1:0] r;
      logic            e;
      int              cyc, starts, lows;
      tick();
      m_hang = 1'b1;
      set_op(2, 8'd5, 8'd5);
      wait_gnt(g);
      req = '0;
      cyc = 0;
      lows = 0;
      while (rsp_valid == '0 && cyc < 200) begin
         tick();
         cyc++;
         if (!m_rstn) lows++;
      end
      n_vec++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL tmo_valid: got %b expected 0100", rsp_valid); end
      n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b expected 1", rsp_err); end
      n_vec++; if (rsp_result !== 16'h0) begin n_err++; $display("FAIL tmo_result: got %h expected 0000", rsp_result); end
      n_vec++; if (cyc !== TO + 1) begin n_err++; $display("FAIL tmo_latency: got %0d expected %0d", cyc, TO + 1); end
      n_vec++; if (lows !== 1 || m_rstn !== 1'b0) begin n_err++; $display("FAIL tmo_m_rstn: got %0d lows/%b expected 1/0", lows, m_rstn); end
      m_hang = 1'b0;
      tick();
      n_vec++; if (m_rstn !== 1'b1) begin n_err++; $display("FAIL tmo_rearm: got %b expected 1", m_rstn); end
      set_op(3, 8'd2, 8'd3);
      wait_gnt(g);
      req = '0;
      wait_rsp(v, r, e, cyc, starts);
      n_vec++; if ({v, e, r} !== {4'b1000, 1'b0, 16'd6}) begin n_err++; $display("FAIL tmo_recover: got %b/%b/%0d expected 1000/0/6", v, e, r); end
   endtask
`endif

   initial begin
      rst   = 1'b1;
      req   = '0;
      req_a = '0;
      req_b = '0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_signed();
      test_reset_midop();
`ifdef MULT_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
